burst_mem_responder: RTL and testbench

Responder end of the 64-bit, 4-beat burst memory interface driven by `cacheline_adapter`. It accepts line-aligned read and write bursts and holds a small internal line store. Read data returns after a programmable latency as four consecutive beats, with ready reasserted on the final beat so the initiator can complete its response. It serves as the synthesizable memory endpoint for cache and adapter benches and for small standalone builds.

---
 rtl/bmem_pkg.sv | 13 +
 rtl/burst_mem_array.sv | 27 ++
 rtl/burst_mem_responder.sv | 120 ++++++++++++
 tb/tb_burst_mem_responder.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/bmem_pkg.sv
// Shared types and constants for the 64-bit, 4-beat burst memory interface.
package bmem_pkg;
  typedef enum logic [1:0] {IDLE, WBURST, RWAIT, RBURST} bmem_state_t;

  localparam int          BEATS     = 4;
  localparam int          BEAT_W    = 64;
  localparam int          LINE_OFF  = 5;
  localparam logic [31:0] LINE_MASK = 32'hFFFF_FFE0;

  function automatic logic [31:0] line_addr(input logic [31:0] a);
    return a & LINE_MASK;
  endfunction
endpackage

// File: rtl/burst_mem_array.sv
// 1W1R word store with synchronous write and a registered synchronous read port.
module burst_mem_array #(
  parameter int WORDS = 64,
  parameter int AW    = 6,
  parameter int DW    = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [WORDS];

  // Storage itself is never reset; only the read register is.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/burst_mem_responder.sv
// Burst memory responder: FSM, latency/beat counters and a line store.
module burst_mem_responder
  import bmem_pkg::*;
#(
  parameter int DEPTH_LINES = 16,
  parameter int READ_LAT    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] bmem_addr,
  input  logic        bmem_read,
  input  logic        bmem_write,
  input  logic [63:0] bmem_wdata,
  output logic        bmem_ready,
  output logic [31:0] bmem_raddr,
  output logic [63:0] bmem_rdata,
  output logic        bmem_rvalid
);
  localparam int          IW       = $clog2(DEPTH_LINES);
  localparam int          AW       = IW + 2;
  localparam logic [3:0]  LAT_INIT = 4'(READ_LAT - 1);

  bmem_state_t   state;
  logic [3:0]    lat_cnt;
  logic [1:0]    beat;
  logic [IW-1:0] widx;
  logic [IW-1:0] ridx;
  logic [1:0]    rbeat;
  logic          can_accept, acc_rd, acc_wr, wr_beat;
  logic          we, re;
  logic [AW-1:0] waddr, raddr;

  assign ridx = bmem_raddr[LINE_OFF +: IW];

  assign bmem_ready = !rst && (state == IDLE || state == WBURST ||
                               (state == RBURST && beat == 2'd3));
  // WBURST is ready only for write beats; new requests start from IDLE or the last read beat.
  assign can_accept = bmem_ready && (state != WBURST);
  assign acc_rd     = can_accept && bmem_read;
  assign acc_wr     = can_accept && !bmem_read && bmem_write;
  assign wr_beat    = bmem_ready && (state == WBURST) && bmem_write;

  assign we    = acc_wr || wr_beat;
  assign waddr = acc_wr ? {bmem_addr[LINE_OFF +: IW], 2'd0} : {widx, beat};

  // Array read is issued one cycle ahead so the registered word lines up with its beat.
  assign rbeat = (state == RWAIT) ? 2'd0 : beat + 2'd1;
  assign re    = (state == RWAIT && lat_cnt == 4'd0) || (state == RBURST && beat != 2'd3);
  assign raddr = {ridx, rbeat};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      lat_cnt     <= '0;
      beat        <= '0;
      widx        <= '0;
      bmem_raddr  <= '0;
      bmem_rvalid <= 1'b0;
    end else begin
      bmem_rvalid <= 1'b0;
      case (state)
        WBURST: begin
          if (bmem_write) begin
            if (beat == 2'd3) begin
              state <= IDLE;
              beat  <= 2'd0;
            end else begin
              beat <= beat + 2'd1;
            end
          end
        end
        RWAIT: begin
          if (lat_cnt == 4'd0) begin
            state       <= RBURST;
            beat        <= 2'd0;
            bmem_rvalid <= 1'b1;
          end else begin
            lat_cnt <= lat_cnt - 4'd1;
          end
        end
        RBURST: begin
          if (beat != 2'd3) begin
            beat        <= beat + 2'd1;
            bmem_rvalid <= 1'b1;
          end else begin
            state <= IDLE;
            beat  <= 2'd0;
          end
        end
        default: ;
      endcase

      if (acc_rd) begin
        state      <= RWAIT;
        lat_cnt    <= LAT_INIT;
        beat       <= 2'd0;
        bmem_raddr <= line_addr(bmem_addr);
      end else if (acc_wr) begin
        state <= WBURST;
        beat  <= 2'd1;
        widx  <= bmem_addr[LINE_OFF +: IW];
      end
    end
  end

  burst_mem_array #(
    .WORDS (DEPTH_LINES * BEATS),
    .AW    (AW),
    .DW    (BEAT_W)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .waddr (waddr),
    .wdata (bmem_wdata),
    .re    (re),
    .raddr (raddr),
    .rdata (bmem_rdata)
  );
endmodule

// File: tb/tb_burst_mem_responder.sv
// Directed bench for burst_mem_responder: writes, reads, stalls, aliasing and reset.
module tb_burst_mem_responder;
  localparam int RL = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] bmem_addr;
  logic        bmem_read, bmem_write;
  logic [63:0] bmem_wdata;
  logic        bmem_ready;
  logic [31:0] bmem_raddr;
  logic [63:0] bmem_rdata;
  logic        bmem_rvalid;

  int checks   = 0;
  int failures = 0;

  burst_mem_responder #(.DEPTH_LINES(16), .READ_LAT(RL)) dut (
    .clk(clk), .rst(rst), .bmem_addr(bmem_addr), .bmem_read(bmem_read),
    .bmem_write(bmem_write), .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready),
    .bmem_raddr(bmem_raddr), .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic write_burst(input logic [31:0] addr, input logic [3:0][63:0] d,
                             input int stall);
    bmem_write = 1'b1; bmem_addr = addr; bmem_wdata = d[0];
    tick();
    chk("wr_ready_b1", {63'd0, bmem_ready}, 64'd1);
    bmem_wdata = d[1];
    tick();
    bmem_write = 1'b0; bmem_wdata = '1;
    for (int i = 0; i < stall; i++) begin
      tick();
      chk("wr_stall_ready", {63'd0, bmem_ready}, 64'd1);
    end
    bmem_write = 1'b1; bmem_wdata = d[2];
    tick();
    bmem_wdata = d[3];
    tick();
    bmem_write = 1'b0; bmem_wdata = '0;
    chk("wr_done_ready", {63'd0, bmem_ready}, 64'd1);
  endtask

  task automatic read_req(input logic [31:0] addr);
    bmem_read = 1'b1; bmem_addr = addr;
    tick();
    bmem_read = 1'b0;
  endtask

  // Starts in the window just after the acceptance edge.
  task automatic read_resp(input logic [31:0] line, input logic [3:0][63:0] d,
                           input bit b2b, input logic [31:0] naddr);
    chk("rd_c0_rvalid", {63'd0, bmem_rvalid}, 64'd0);
    chk("rd_c0_ready", {63'd0, bmem_ready}, 64'd0);
    for (int c = 1; c < RL; c++) begin
      tick();
      chk("rd_wait_rvalid", {63'd0, bmem_rvalid}, 64'd0);
    end
    for (int b = 0; b < 4; b++) begin
      tick();
      chk("rd_rvalid", {63'd0, bmem_rvalid}, 64'd1);
      chk("rd_rdata", bmem_rdata, d[b]);
      chk("rd_raddr", {32'd0, bmem_raddr}, {32'd0, line});
      chk("rd_ready", {63'd0, bmem_ready}, (b == 3) ? 64'd1 : 64'd0);
    end
    if (b2b) begin
      read_req(naddr);
    end else begin
      tick();
      chk("rd_end_rvalid", {63'd0, bmem_rvalid}, 64'd0);
      chk("rd_end_ready", {63'd0, bmem_ready}, 64'd1);
    end
  endtask

  logic [3:0][63:0] d1, d2, d3;

  initial begin
    d1 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
          64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    d2 = {64'hDDDD_0003_0000_0000, 64'hCCCC_0002_0000_0000,
          64'hBBBB_0001_0000_0000, 64'hAAAA_0000_0000_0000};
    d3 = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
          64'h5A5A_5A5A_A5A5_A5A5, 64'hDEAD_BEEF_CAFE_F00D};

    rst = 1'b1; bmem_addr = '0; bmem_read = 1'b0; bmem_write = 1'b0; bmem_wdata = '0;
    #1;
    chk("rst_ready", {63'd0, bmem_ready}, 64'd0);
    chk("rst_rvalid", {63'd0, bmem_rvalid}, 64'd0);
    chk("rst_rdata", bmem_rdata, 64'd0);
    chk("rst_raddr", {32'd0, bmem_raddr}, 64'd0);
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("post_rst_ready", {63'd0, bmem_ready}, 64'd1);

    // Write then read with an unaligned address inside the line
    write_burst(32'h0000_0040, d1, 0);
    read_req(32'h0000_0047);
    read_resp(32'h0000_0040, d1, 1'b0, '0);

    // Read wins over a simultaneous write; line must be unchanged
    bmem_write = 1'b1; bmem_wdata = 64'hBAD0_BAD0_BAD0_BAD0;
    read_req(32'h0000_0040);
    bmem_write = 1'b0;
    read_resp(32'h0000_0040, d1, 1'b0, '0);
    read_req(32'h0000_0040);
    read_resp(32'h0000_0040, d1, 1'b0, '0);

    // Write burst stalled for 3 cycles between beats 1 and 2
    write_burst(32'h0000_0080, d2, 3);
    read_req(32'h0000_0080);
    read_resp(32'h0000_0080, d2, 1'b0, '0);

    // Back-to-back reads accepted on the beat-3 cycle
    read_req(32'h0000_0040);
    read_resp(32'h0000_0040, d1, 1'b1, 32'h0000_0098);
    read_resp(32'h0000_0080, d2, 1'b0, '0);

    // Aliasing: 0x200 and 0x000 share index 0 with 16 lines
    write_burst(32'h0000_0200, d3, 0);
    read_req(32'h0000_0000);
    read_resp(32'h0000_0000, d3, 1'b0, '0);

    // Reset during RWAIT abandons the read
    read_req(32'h0000_0040);
    tick();
    rst = 1'b1;
    #1;
    chk("midrst_ready", {63'd0, bmem_ready}, 64'd0);
    chk("midrst_rvalid", {63'd0, bmem_rvalid}, 64'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("midrst_release_ready", {63'd0, bmem_ready}, 64'd1);
    for (int i = 0; i < RL + 4; i++) begin
      tick();
      chk("midrst_no_rvalid", {63'd0, bmem_rvalid}, 64'd0);
    end
    read_req(32'h0000_021F);
    read_resp(32'h0000_0200, d3, 1'b0, '0);
    read_req(32'h0000_0040);
    read_resp(32'h0000_0040, d1, 1'b0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
